// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: channel count, per-channel
// FSM encoding and a counter-width helper.
package btn_pkg;

  localparam int unsigned NUM_BTN = 4;

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StRepeat
  } btn_state_e;

  // Width of a counter that must hold 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, counting debouncer and the press /
// long-press / auto-repeat FSM. All outputs come straight from flops.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 1_000_000,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int unsigned DbW   = cnt_width(DB_CYCLES);
  localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);
  localparam int unsigned RepW  = cnt_width(REPEAT_CYCLES);

  localparam logic [DbW-1:0]   DbLast   = DbW'(DB_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [RepW-1:0]  RepLast  = RepW'(REPEAT_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic             level_q;
  btn_state_e       state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RepW-1:0]  rep_cnt_q, rep_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             rise, fall;

  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DbLast) begin
        deb_d = ~deb_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  // level_q trails deb_q by one cycle so the edge pulses line up with the level change.
  assign rise = deb_q & ~level_q;
  assign fall = ~deb_q & level_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d    = StPressed;
          hold_cnt_d = '0;
          press_d    = 1'b1;
        end
      end
      StPressed: begin
        if (fall) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end else if (hold_cnt_q == HoldLast) begin
          state_d   = StRepeat;
          rep_cnt_d = '0;
          long_d    = 1'b1;
          press_d   = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StRepeat: begin
        // A release wins over a repeat due in the same cycle.
        if (fall) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end else if (rep_cnt_q == RepLast) begin
          rep_cnt_d = '0;
          press_d   = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + RepW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      db_cnt_q   <= '0;
      level_q    <= 1'b0;
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      db_cnt_q   <= db_cnt_d;
      level_q    <= deb_q;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;

endmodule

// File: rtl/btn_conditioner.sv
// Board button conditioner: NUM_BTN independent debounced channels producing
// level, press/auto-repeat, release and long-press signals.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 1_000_000,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    btn_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[g]),
      .btn_level  (btn_level[g]),
      .btn_press  (btn_press[g]),
      .btn_release(btn_release[g]),
      .btn_long   (btn_long[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios with literal timing plus a
// randomized run compared every cycle against a behavioural model.
module tb_btn_conditioner;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 20;
  localparam int unsigned REP  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_long;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DB_CYCLES    (DB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model: raw is seen two edges late; the debounced value flips once
  // the last DB seen samples all disagree with it; outputs show it one edge later.
  // Press/long/repeat follow from time elapsed since the press edge.
  bit         m_sp1 [4];
  bit         m_sp2 [4];
  bit         m_sh  [4][DB];
  bit         m_int [4];
  bit         m_out [4];
  int         m_pt  [4];
  int         m_cyc = 0;
  bit [3:0]   e_level = '0, e_press = '0, e_rel = '0, e_long = '0;
  bit         m_s, m_nout, m_diff;
  int         m_e;

  always begin
    @(posedge clk);
    m_cyc++;
    for (int mi = 0; mi < 4; mi++) begin
      e_press[mi] = 1'b0;
      e_rel[mi]   = 1'b0;
      e_long[mi]  = 1'b0;
      if (rst) begin
        m_sp1[mi] = 1'b0;
        m_sp2[mi] = 1'b0;
        for (int mj = 0; mj < DB; mj++) m_sh[mi][mj] = 1'b0;
        m_int[mi] = 1'b0;
        m_out[mi] = 1'b0;
      end else begin
        m_s       = m_sp2[mi];
        m_sp2[mi] = m_sp1[mi];
        m_sp1[mi] = btn_raw[mi];
        for (int mj = DB - 1; mj > 0; mj--) m_sh[mi][mj] = m_sh[mi][mj-1];
        m_sh[mi][0] = m_s;
        m_diff = 1'b1;
        for (int mj = 0; mj < DB; mj++) if (m_sh[mi][mj] == m_int[mi]) m_diff = 1'b0;
        m_nout = m_int[mi];
        if (m_nout && !m_out[mi]) begin
          e_press[mi] = 1'b1;
          m_pt[mi]    = m_cyc;
        end else if (!m_nout && m_out[mi]) begin
          e_rel[mi] = 1'b1;
        end else if (m_nout) begin
          m_e = m_cyc - m_pt[mi];
          if (m_e == HOLD) e_long[mi] = 1'b1;
          if (m_e >= HOLD && ((m_e - HOLD) % REP) == 0) e_press[mi] = 1'b1;
        end
        if (m_diff) m_int[mi] = ~m_int[mi];
        m_out[mi] = m_nout;
      end
      e_level[mi] = m_out[mi];
    end
    #1;
    check("cycle_model", {16'h0, btn_level, btn_press, btn_release, btn_long},
          {16'h0, e_level, e_press, e_rel, e_long});
  end

  int unsigned press_cnt [4] = '{default: 0};
  int unsigned rel_cnt   [4] = '{default: 0};
  int unsigned long_cnt  [4] = '{default: 0};

  always @(negedge clk) begin
    for (int ci = 0; ci < 4; ci++) begin
      press_cnt[ci] += btn_press[ci];
      rel_cnt[ci]   += btn_release[ci];
      long_cnt[ci]  += btn_long[ci];
    end
  end

  int unsigned pc, rc, lc;
  int          rem [4];
  int          rst_left;

  initial begin
    rst     = 1'b1;
    btn_raw = '0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("reset_outputs", {btn_level, btn_press, btn_release, btn_long}, 0);
    end
    @(negedge clk) rst = 1'b0;
    tick(3);

    // Clean press on button 0, held 10 cycles.
    pc = press_cnt[0]; rc = rel_cnt[0]; lc = long_cnt[0];
    @(negedge clk) btn_raw[0] = 1'b1;
    tick(6);
    check("clean_level_before", btn_level[0], 0);
    tick(1);
    check("clean_level_rise", btn_level[0], 1);
    check("clean_press", btn_press[0], 1);
    tick(1);
    check("clean_press_single", btn_press[0], 0);
    tick(2);
    @(negedge clk) btn_raw[0] = 1'b0;
    tick(6);
    check("clean_release_early", btn_release[0], 0);
    tick(1);
    check("clean_release", btn_release[0], 1);
    check("clean_level_fall", btn_level[0], 0);
    tick(4);
    check("clean_press_count", press_cnt[0] - pc, 1);
    check("clean_release_count", rel_cnt[0] - rc, 1);
    check("clean_long_count", long_cnt[0] - lc, 0);

    // Button 1 bouncing every 2 cycles, then stable high.
    pc = press_cnt[1]; rc = rel_cnt[1];
    for (int k = 0; k < 10; k++) begin
      @(negedge clk) btn_raw[1] = ((k % 2) == 0);
      @(negedge clk);
    end
    btn_raw[1] = 1'b1;
    tick(10);
    check("bounce_press_count", press_cnt[1] - pc, 1);
    check("bounce_release_count", rel_cnt[1] - rc, 0);
    check("bounce_level", btn_level[1], 1);
    @(negedge clk) btn_raw[1] = 1'b0;
    tick(10);

    // Button 2 held 40 cycles: long press, auto-repeat, release on a due repeat.
    pc = press_cnt[2]; rc = rel_cnt[2]; lc = long_cnt[2];
    @(negedge clk) btn_raw[2] = 1'b1;
    tick(7);
    check("hold_first_press", {btn_press[2], btn_long[2]}, 2'b10);
    tick(20);
    check("hold_long_press", {btn_press[2], btn_long[2]}, 2'b11);
    tick(5);
    check("hold_repeat", {btn_press[2], btn_long[2]}, 2'b10);
    tick(8);
    @(negedge clk) btn_raw[2] = 1'b0;
    tick(6);
    check("hold_pre_release", {btn_press[2], btn_release[2]}, 2'b00);
    tick(1);
    check("hold_release_suppress", {btn_press[2], btn_release[2]}, 2'b01);
    tick(3);
    check("hold_press_count", press_cnt[2] - pc, 5);
    check("hold_long_count", long_cnt[2] - lc, 1);
    check("hold_release_count", rel_cnt[2] - rc, 1);

    // All four together.
    @(negedge clk) btn_raw = 4'hF;
    tick(7);
    check("all_press", btn_press, 4'hF);
    check("all_level", btn_level, 4'hF);
    @(negedge clk) btn_raw = 4'h0;
    tick(10);

    // Reset while button 3 is auto-repeating.
    @(negedge clk) btn_raw[3] = 1'b1;
    tick(30);
    rc = rel_cnt[3];
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("midrst_outputs", {btn_level, btn_press, btn_release, btn_long}, 0);
    end
    @(negedge clk) rst = 1'b0;
    tick(6);
    check("midrst_before_press", {btn_level[3], btn_press[3]}, 2'b00);
    tick(1);
    check("midrst_new_press", {btn_level[3], btn_press[3]}, 2'b11);
    tick(2);
    check("midrst_no_release", rel_cnt[3] - rc, 0);
    @(negedge clk) btn_raw[3] = 1'b0;
    tick(10);

    // Randomized mix of bounces, long holds and occasional resets.
    for (int k = 0; k < 4; k++) rem[k] = 0;
    rst_left = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (rst_left > 0) begin
        rst_left--;
        rst = 1'b1;
      end else if ($urandom_range(0, 799) == 0) begin
        rst      = 1'b1;
        rst_left = $urandom_range(0, 2);
      end else begin
        rst = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
        if (rem[k] == 0) begin
          btn_raw[k] = 1'($urandom_range(0, 1));
          rem[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(3, 60);
        end else begin
          rem[k]--;
        end
      end
    end
    @(negedge clk);
    rst     = 1'b0;
    btn_raw = '0;
    tick(12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
